wishbone_rr_arbiter: RTL and testbench



---
 rtl/wishbone_arb_pkg.sv | 20 ++
 rtl/rr_picker.sv | 36 +++
 rtl/wishbone_rr_arbiter.sv | 154 +++++++++++++++
 tb/tb_wishbone_rr_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wishbone_arb_pkg.sv
// wishbone_arb_pkg
// Shared types and constants for the Wishbone round-robin arbiter.
//   arb_state_e       : arbiter FSM states (IDLE, GRANT)
//   N_MASTERS_DEFAULT : default number of requesting masters
//   last_owner_reset  : reset value of the round-robin pointer, chosen so
//                       that master 0 is searched first after reset
package wishbone_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int N_MASTERS_DEFAULT = 3;

  function automatic int last_owner_reset(input int n_masters);
    return n_masters - 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker
// Purely combinational round-robin picker. The search starts one position
// after last_owner and wraps modulo N_MASTERS; the first eligible bit wins.
// Ports:
//   eligible   : in,  N_MASTERS  - requests that may be granted
//   last_owner : in,  W_SEL      - index of the most recent owner
//   winner     : out, W_SEL      - chosen index (0 when nothing is found)
//   found      : out, 1          - at least one eligible request exists
module rr_picker #(
  parameter int N_MASTERS = 3,
  parameter int W_SEL     = $clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] eligible,
  input  logic [W_SEL-1:0]     last_owner,
  output logic [W_SEL-1:0]     winner,
  output logic                 found
);

  int idx;

  // Walk offsets 1..N so the previous owner is considered last; the found
  // flag freezes the first hit while the loop keeps a fixed trip count.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      idx = (int'(last_owner) + k) % N_MASTERS;
      if (!found && eligible[idx]) begin
        winner = W_SEL'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wishbone_rr_arbiter.sv
// wishbone_rr_arbiter
// Round-robin arbiter for the shared Wishbone bus. Ownership is held for a
// whole bus cycle (cyc rise to cyc fall); when the owner releases, the next
// requester is selected in the same cycle so handover has no idle bubble.
// Optional feature macro: WB_ARB_TIMEOUT_EN adds a watchdog that revokes
// ownership after TIMEOUT_CYCLES cycles without ack and masks the offender
// until it drops its request.
// Ports:
//   clk          : in,  1         - bus clock
//   rstn         : in,  1         - asynchronous active-low reset
//   req          : in,  N_MASTERS - cyc of each master
//   ack          : in,  1         - ack from the shared slave side
//   slave_select : out, W_SEL     - registered owner index (mux select)
//   grant        : out, N_MASTERS - one-hot owner, zero when idle
//   bus_en       : out, 1         - high while a grant is active
//   timeout_err  : out, 1         - one-cycle pulse on revocation
module wishbone_rr_arbiter
  import wishbone_arb_pkg::*;
#(
  parameter int N_MASTERS      = N_MASTERS_DEFAULT,
  parameter int W_SEL          = $clog2(N_MASTERS),
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_MASTERS-1:0] req,
  input  logic                 ack,
  output logic [W_SEL-1:0]     slave_select,
  output logic [N_MASTERS-1:0] grant,
  output logic                 bus_en,
  output logic                 timeout_err
);

  localparam logic [N_MASTERS-1:0] ONE_HOT_0      = {{(N_MASTERS-1){1'b0}}, 1'b1};
  localparam logic [W_SEL-1:0]     LAST_OWNER_RST = W_SEL'(last_owner_reset(N_MASTERS));

  arb_state_e             state, state_next;
  logic [W_SEL-1:0]       owner, owner_next;
  logic [W_SEL-1:0]       last_owner, last_owner_next;
  logic [N_MASTERS-1:0]   owner_onehot;
  logic [N_MASTERS-1:0]   pick_vec;
  logic [W_SEL-1:0]       pick_winner;
  logic                   pick_found;
  logic                   new_grant;
  logic                   timeout_hit;
  logic [N_MASTERS-1:0]   mask_q;

  assign owner_onehot = ONE_HOT_0 << owner;

  // The current owner is never a candidate while it holds the bus: either it
  // has released, or the watchdog is revoking it.
  assign pick_vec = req & ~mask_q & ((state == GRANT) ? ~owner_onehot : '1);

  rr_picker #(
    .N_MASTERS (N_MASTERS),
    .W_SEL     (W_SEL)
  ) u_picker (
    .eligible   (pick_vec),
    .last_owner (last_owner),
    .winner     (pick_winner),
    .found      (pick_found)
  );

  // Next-state logic: requests from others are ignored while the owner keeps
  // cyc high, so block cycles are never split.
  always_comb begin
    state_next      = state;
    owner_next      = owner;
    last_owner_next = last_owner;
    new_grant       = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_next      = GRANT;
          owner_next      = pick_winner;
          last_owner_next = pick_winner;
          new_grant       = 1'b1;
        end
      end
      GRANT: begin
        if (!req[owner] || timeout_hit) begin
          if (pick_found) begin
            owner_next      = pick_winner;
            last_owner_next = pick_winner;
            new_grant       = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and ownership registers; grant is recomputed from the next state so
  // it never shows a stale owner, and reset drops it immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= LAST_OWNER_RST;
      grant      <= '0;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      last_owner <= last_owner_next;
      grant      <= (state_next == GRANT) ? (ONE_HOT_0 << owner_next) : '0;
    end
  end

  assign slave_select = owner;
  assign bus_en       = (state == GRANT);

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_count;
  logic             timeout_err_q;

  // The counter is 0 in the first cycle of every grant, so reaching
  // TIMEOUT_CYCLES-1 means that many grant cycles passed without ack.
  assign timeout_hit = (state == GRANT) && !ack &&
                       (wd_count == CNT_W'(TIMEOUT_CYCLES - 1));

  // A revoked master stays masked until it drops cyc, so it cannot grab the
  // bus again with the same hung cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_count      <= '0;
      mask_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= timeout_hit;
      mask_q        <= (mask_q & req) | (timeout_hit ? owner_onehot : '0);
      if (new_grant || ack || state != GRANT) begin
        wd_count <= '0;
      end else begin
        wd_count <= wd_count + 1'b1;
      end
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_ack;
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign unused_ack  = ack;
  assign mask_q      = '0;
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// tb_wishbone_rr_arbiter
// Self-checking bench for wishbone_rr_arbiter. Each applied input vector is
// run through a behavioural model and the expected outputs are queued; after
// the clock edge the entry is popped and compared against the DUT.
// Honours WB_ARB_TIMEOUT_EN (timeout tests expect revocation only when set).
module tb_wishbone_rr_arbiter;

  localparam int N  = 3;
  localparam int TO = 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk;
  logic       rstn;
  logic [2:0] req;
  logic       ack;
  logic [1:0] slave_select;
  logic [2:0] grant;
  logic       bus_en;
  logic       timeout_err;

  typedef struct {
    logic [2:0] grant;
    logic [1:0] sel;
    logic       busEn;
    logic       terr;
  } expect_t;

  expect_t expQ[$];

  int testsRun    = 0;
  int testsFailed = 0;

  bit         mBusy;
  int         mOwner;
  int         mLast;
  logic [2:0] mMask;
  int         mCnt;

  int         orderSeen[$];
  int         expOrder[6] = '{0, 1, 2, 0, 1, 2};
  int         terrCount;
  logic [1:0] lastSeen;

  wishbone_rr_arbiter #(
    .N_MASTERS      (N),
    .W_SEL          (2),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req          (req),
    .ack          (ack),
    .slave_select (slave_select),
    .grant        (grant),
    .bus_en       (bus_en),
    .timeout_err  (timeout_err)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the bench ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Behavioural reference: advance one clock edge with the given inputs and
  // queue the outputs expected right after that edge.
  task automatic modelStep(input logic [2:0] r, input logic a);
    bit         timeout;
    bit         release_bus;
    bit         found;
    int         w;
    int         idx;
    logic [2:0] cand;
    logic [2:0] oldOH;
    expect_t    e;
    timeout     = TO_EN && mBusy && (mCnt == TO - 1) && !a;
    release_bus = mBusy && (!r[mOwner] || timeout);
    oldOH       = 3'b001 << mOwner;
    cand        = r & ~mMask;
    if (mBusy) cand = cand & ~oldOH;
    found = 1'b0;
    w     = 0;
    if (!mBusy || release_bus) begin
      for (int k = 1; k <= N; k++) begin
        idx = (mLast + k) % N;
        if (!found && cand[idx]) begin
          found = 1'b1;
          w     = idx;
        end
      end
    end
    if (found) begin
      mBusy  = 1'b1;
      mOwner = w;
      mLast  = w;
      mCnt   = 0;
    end else if (release_bus) begin
      mBusy = 1'b0;
      mCnt  = 0;
    end else if (mBusy) begin
      mCnt = a ? 0 : mCnt + 1;
    end
    mMask   = TO_EN ? ((mMask & r) | (timeout ? oldOH : 3'b000)) : 3'b000;
    e.grant = mBusy ? (3'b001 << mOwner) : 3'b000;
    e.sel   = 2'(mOwner);
    e.busEn = mBusy;
    e.terr  = timeout;
    expQ.push_back(e);
  endtask

  task automatic checkCycle();
    expect_t e;
    if (expQ.size() == 0) begin
      checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd1);
    end else begin
      e = expQ.pop_front();
      checkOutput("grant", 32'(grant), 32'(e.grant));
      checkOutput("slave_select", 32'(slave_select), 32'(e.sel));
      checkOutput("bus_en", 32'(bus_en), 32'(e.busEn));
      checkOutput("timeout_err", 32'(timeout_err), 32'(e.terr));
    end
  endtask

  // Drive one cycle of inputs at the falling edge and check just after the
  // following rising edge.
  task automatic applyStimulus(input logic [2:0] r, input logic a);
    @(negedge clk);
    req = r;
    ack = a;
    modelStep(r, a);
    @(posedge clk);
    #1;
    checkCycle();
    if (timeout_err === 1'b1) terrCount++;
  endtask

  // Reset is asserted mid-cycle so the asynchronous drop of grant is seen.
  task automatic applyReset();
    #2;
    rstn = 1'b0;
    req  = 3'b000;
    ack  = 1'b0;
    #1;
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_bus_en", 32'(bus_en), 32'd0);
    checkOutput("rst_select", 32'(slave_select), 32'd0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
    mBusy  = 1'b0;
    mOwner = 0;
    mLast  = N - 1;
    mMask  = 3'b000;
    mCnt   = 0;
    expQ.delete();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b1;
    req  = 3'b000;
    ack  = 1'b0;
    terrCount = 0;

    // Reset, then a single request from master 0.
    applyReset();
    applyStimulus(3'b001, 1'b1);
    applyStimulus(3'b001, 1'b1);
    applyStimulus(3'b000, 1'b0);

    // All masters requesting; each owner drops cyc for one cycle after 4 beats.
    applyReset();
    lastSeen = 2'd0;
    for (int g = 0; g < 6; g++) begin
      for (int b = 0; b < 4; b++) begin
        applyStimulus(3'b111, 1'b1);
        if (bus_en && (orderSeen.size() == 0 || slave_select != lastSeen)) begin
          orderSeen.push_back(int'(slave_select));
          lastSeen = slave_select;
        end
      end
      applyStimulus(3'b111 & ~(3'b001 << expOrder[g]), 1'b1);
      if (bus_en && (orderSeen.size() == 0 || slave_select != lastSeen)) begin
        orderSeen.push_back(int'(slave_select));
        lastSeen = slave_select;
      end
    end
    checkOutput("order_count_ge6", 32'(orderSeen.size() >= 6), 32'd1);
    for (int i = 0; i < 6; i++) begin
      if (i < orderSeen.size())
        checkOutput($sformatf("order_%0d", i), 32'(orderSeen[i]), 32'(expOrder[i]));
    end

    // Block cycle: master 1 holds cyc for 20 cycles against 0 and 2.
    applyReset();
    applyStimulus(3'b010, 1'b1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(3'b111, 1'b1);
      checkOutput("hold_grant", 32'(grant), 32'b010);
    end
    applyStimulus(3'b101, 1'b1);
    checkOutput("hold_next_grant", 32'(grant), 32'b100);

    // Owner 2 releases with nobody else asking.
    applyStimulus(3'b000, 1'b0);
    checkOutput("idle_grant", 32'(grant), 32'd0);
    checkOutput("idle_bus_en", 32'(bus_en), 32'd0);
    checkOutput("idle_select_kept", 32'(slave_select), 32'd2);

    // Reset while a grant is active.
    applyStimulus(3'b010, 1'b1);
    applyReset();

    // Master 0 hangs with no ack while master 1 also requests.
    terrCount = 0;
    for (int i = 0; i < 10; i++) applyStimulus(3'b011, 1'b0);
    checkOutput("timeout_pulses", 32'(terrCount), TO_EN ? 32'd1 : 32'd0);
    checkOutput("timeout_new_owner", 32'(grant), TO_EN ? 32'b010 : 32'b001);
    applyStimulus(3'b001, 1'b0);
    checkOutput("masked_no_regrant", 32'(grant), TO_EN ? 32'b000 : 32'b001);
    applyStimulus(3'b000, 1'b0);
    applyStimulus(3'b001, 1'b1);
    checkOutput("unmasked_regrant", 32'(grant), 32'b001);

    // Periodic ack keeps the watchdog from firing.
    applyReset();
    terrCount = 0;
    for (int i = 0; i < 100; i++) applyStimulus(3'b011, (i % 5) == 4);
    checkOutput("ack_no_timeout", 32'(terrCount), 32'd0);

    // Random traffic against the model.
    applyReset();
    for (int i = 0; i < 300; i++)
      applyStimulus(3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
